mem_arbiter: RTL and testbench

- Round-robin arbiter that shares the single memory request/response channel between NUM_REQ requesters, e.g. the cpu and future accelerator engines.
- Sits between the requesters and the memory block.
- Admits one transaction at a time, holds it until the memory accepts it, then routes the response back to the owning requester.
- Holds off all grants until the shared buffer address is valid.

---
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response bundle shared by the requesters, the arbiter and the memory.
interface mem_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 512
);
  logic                        buffer_addr_valid;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_write;
  logic [NUM_REQ*ADDR_W-1:0]   req_addr;
  logic [NUM_REQ*DATA_W-1:0]   req_data;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0]          rsp_valid;
  logic [DATA_W-1:0]           rsp_data;
  logic                        mem_req_valid;
  logic                        mem_req_write;
  logic [ADDR_W-1:0]           mem_req_addr;
  logic [DATA_W-1:0]           mem_req_data;
  logic                        mem_req_ready;
  logic                        mem_rsp_valid;
  logic [DATA_W-1:0]           mem_rsp_data;
  logic                        busy;
  logic                        err;

  // Arbiter side.
  modport slave (
    input  buffer_addr_valid, req_valid, req_write, req_addr, req_data,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output req_ready, rsp_valid, rsp_data,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_data,
    output busy, err
  );

  // Requester/memory side.
  modport master (
    output buffer_addr_valid, req_valid, req_write, req_addr, req_data,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  req_ready, rsp_valid, rsp_data,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_data,
    input  busy, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory request/response channel between
// NUM_REQ requesters; one transaction in flight at a time.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no transaction; grants the next requester when buffer valid
// ST_ISSUE | latched request presented to memory, waiting for ready
// ST_WAIT  | request accepted, waiting for the memory response
module mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 512
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [IDX_W-1:0]    r_last_grant;
  logic [IDX_W-1:0]    r_owner;
  logic [IDX_W-1:0]    w_winner;
  logic                w_any_req;
  logic                w_grant;
  logic                w_rsp_accept;
  logic [NUM_REQ-1:0]  w_req_ready;
  logic                w_sel_write;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_data;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_err;

  // Pick the first pending requester scanning upward from one past the last grant.
  always_comb begin
    w_any_req = 1'b0;
    w_winner  = r_last_grant;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_any_req && bus.req_valid[i] &&
            (i == (int'(r_last_grant) + k) % NUM_REQ)) begin
          w_any_req = 1'b1;
          w_winner  = IDX_W'(i);
        end
      end
    end
  end

  // Mux the winner's request fields out of the packed buses.
  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == IDX_W'(i)) begin
        w_sel_write = bus.req_write[i];
        w_sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        w_sel_data  = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and handshake decode; grants are gated by reset so nothing is
  // accepted while rst_n is low.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_rsp_accept = 1'b0;
    w_req_ready  = '0;
    case (r_state)
      ST_IDLE: begin
        if (rst_n && bus.buffer_addr_valid && w_any_req) begin
          w_grant      = 1'b1;
          w_next_state = ST_ISSUE;
          for (int i = 0; i < NUM_REQ; i++) begin
            w_req_ready[i] = (w_winner == IDX_W'(i));
          end
        end
      end
      ST_ISSUE: begin
        if (bus.mem_req_ready) begin
          w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.mem_rsp_valid) begin
          w_rsp_accept = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch the granted request and remember the owner for response routing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_owner      <= '0;
      r_last_grant <= LAST_IDX;
    end else if (w_grant) begin
      r_write      <= w_sel_write;
      r_addr       <= w_sel_addr;
      r_data       <= w_sel_data;
      r_owner      <= w_winner;
      r_last_grant <= w_winner;
    end
  end

  // Register the response pulse and data; flag responses arriving outside ST_WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_rsp_valid[i] <= w_rsp_accept && (r_owner == IDX_W'(i));
      end
      if (w_rsp_accept) begin
        r_rsp_data <= bus.mem_rsp_data;
      end
      if (bus.mem_rsp_valid && (r_state != ST_WAIT)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.req_ready     = w_req_ready;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_data      = r_rsp_data;
  assign bus.mem_req_valid = (r_state == ST_ISSUE);
  assign bus.mem_req_write = r_write;
  assign bus.mem_req_addr  = r_addr;
  assign bus.mem_req_data  = r_data;
  assign bus.busy          = (r_state != ST_IDLE);
  assign bus.err           = r_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized
// transactions, all compared against a transaction-level round-robin model.
module tb_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 512;

  logic clk;
  logic rst_n;

  mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  // Requester-side pending requests.
  logic          p_valid [N];
  logic          p_write [N];
  logic [AW-1:0] p_addr  [N];
  logic [DW-1:0] p_data  [N];

  // Reference model state.
  int            m_ptr;
  logic          m_err;
  logic          m_err_pend;
  logic          rsp_pending;
  int            exp_owner;
  logic [DW-1:0] exp_data;
  logic [DW-1:0] m_rsp_data;
  int            last_grant_cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] d;
    d = '0;
    for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    return N'(1) << w;
  endfunction

  function automatic int n_pending();
    int c;
    c = 0;
    for (int i = 0; i < N; i++) if (p_valid[i]) c++;
    return c;
  endfunction

  // Round-robin rule: first pending requester after the last grant, with wrap.
  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) begin
      if (p_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_valid[i] = 1'b1;
    p_write[i] = wr;
    p_addr[i]  = a;
    p_data[i]  = d;
  endtask

  task automatic rand_req(input int i);
    set_req(i, 1'($urandom_range(0, 1)), {$urandom, $urandom}, rand_line());
  endtask

  task automatic drive_reqs();
    bus.req_valid = {p_valid[3], p_valid[2], p_valid[1], p_valid[0]};
    bus.req_write = {p_write[3], p_write[2], p_write[1], p_write[0]};
    bus.req_addr  = {p_addr[3], p_addr[2], p_addr[1], p_addr[0]};
    bus.req_data  = {p_data[3], p_data[2], p_data[1], p_data[0]};
  endtask

  // Inputs are driven 2 time units after the edge and sampled one unit later.
  task automatic begin_cycle();
    @(posedge clk);
    #2;
    cyc++;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = rand_line();
    if (m_err_pend) m_err = 1'b1;
    m_err_pend = 1'b0;
  endtask

  task automatic sample();
    #1;
    if (rsp_pending) m_rsp_data = exp_data;
    check_eq("rsp_valid", DW'(bus.rsp_valid), DW'(rsp_pending ? onehot(exp_owner) : N'(0)));
    check_eq("rsp_data", bus.rsp_data, m_rsp_data);
    check_eq("err", DW'(bus.err), DW'(m_err));
    rsp_pending = 1'b0;
  endtask

  task automatic idle_cycle(input logic bav);
    begin_cycle();
    bus.buffer_addr_valid = bav;
    drive_reqs();
    sample();
    check_eq("idle_req_ready", DW'(bus.req_ready), DW'(0));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      p_valid[i] = 1'b0;
      p_write[i] = 1'b0;
      p_addr[i]  = '0;
      p_data[i]  = '0;
    end
    bus.buffer_addr_valid = 1'b0;
    drive_reqs();
    begin_cycle();
    begin_cycle();
    rst_n       = 1'b1;
    m_ptr       = N - 1;
    m_err       = 1'b0;
    m_err_pend  = 1'b0;
    rsp_pending = 1'b0;
    m_rsp_data  = '0;
    begin_cycle();
    sample();
    check_eq("rst_req_ready", DW'(bus.req_ready), DW'(0));
    check_eq("rst_busy", DW'(bus.busy), DW'(0));
    check_eq("rst_mem_req_valid", DW'(bus.mem_req_valid), DW'(0));
    check_eq("rst_mem_req_write", DW'(bus.mem_req_write), DW'(0));
    check_eq("rst_mem_req_addr", DW'(bus.mem_req_addr), DW'(0));
    check_eq("rst_mem_req_data", bus.mem_req_data, DW'(0));
  endtask

  // One full transaction: grant, d1 extra cycles before memory accepts,
  // d2 extra cycles before the response. The response itself is checked in
  // the following cycle by sample().
  task automatic do_txn(input int d1, input int d2, input logic [DW-1:0] mdata,
                        input bit refill, input bit jitter, input logic [N-1:0] add_mask,
                        output int w, output int gap);
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    begin_cycle();
    bus.buffer_addr_valid = 1'b1;
    drive_reqs();
    w = rr_pick();
    sample();
    check_eq("busy_idle", DW'(bus.busy), DW'(0));
    check_eq("req_ready", DW'(bus.req_ready), DW'((w < 0) ? N'(0) : onehot(w)));
    gap = cyc - last_grant_cyc;
    last_grant_cyc = cyc;
    if (w < 0) return;
    ew = p_write[w];
    ea = p_addr[w];
    ed = p_data[w];
    m_ptr = w;
    if (!refill) p_valid[w] = 1'b0;
    for (int i = 0; i < N; i++) if (add_mask[i]) rand_req(i);
    for (int k = 0; k <= d1; k++) begin
      begin_cycle();
      if (jitter) bus.buffer_addr_valid = 1'($urandom_range(0, 1));
      drive_reqs();
      bus.mem_req_ready = (k == d1);
      sample();
      check_eq("issue_valid", DW'(bus.mem_req_valid), DW'(1));
      check_eq("issue_write", DW'(bus.mem_req_write), DW'(ew));
      check_eq("issue_addr", DW'(bus.mem_req_addr), DW'(ea));
      check_eq("issue_data", bus.mem_req_data, ed);
      check_eq("issue_req_ready", DW'(bus.req_ready), DW'(0));
      check_eq("issue_busy", DW'(bus.busy), DW'(1));
    end
    for (int k = 0; k <= d2; k++) begin
      begin_cycle();
      if (jitter) bus.buffer_addr_valid = 1'($urandom_range(0, 1));
      drive_reqs();
      if (k == d2) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = mdata;
      end
      sample();
      check_eq("wait_mem_req_valid", DW'(bus.mem_req_valid), DW'(0));
      check_eq("wait_req_ready", DW'(bus.req_ready), DW'(0));
      check_eq("wait_busy", DW'(bus.busy), DW'(1));
    end
    rsp_pending = 1'b1;
    exp_owner   = w;
    exp_data    = mdata;
  endtask

  int exp_order [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    int w;
    int gap;
    rst_n = 1'b0;
    bus.buffer_addr_valid = 1'b0;
    bus.mem_req_ready     = 1'b0;
    bus.mem_rsp_valid     = 1'b0;
    bus.mem_rsp_data      = '0;
    last_grant_cyc        = 0;
    apply_reset();

    // Grants are held off while the buffer address is invalid.
    p_valid[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      idle_cycle(1'b0);
      check_eq("hold_mem_req_valid", DW'(bus.mem_req_valid), DW'(0));
      check_eq("hold_busy", DW'(bus.busy), DW'(0));
    end
    p_valid[0] = 1'b0;

    // Requester 2 reads 0x1000; memory answers 5 cycles after accept.
    set_req(2, 1'b0, 64'h1000, rand_line());
    do_txn(0, 4, {64{8'hAA}}, 1'b0, 1'b0, '0, w, gap);
    check_eq("read_owner", DW'(w), DW'(2));
    idle_cycle(1'b1);

    // All four held valid with zero-latency memory.
    apply_reset();
    for (int i = 0; i < N; i++) rand_req(i);
    for (int t = 0; t < 6; t++) begin
      do_txn(0, 0, rand_line(), 1'b1, 1'b0, '0, w, gap);
      check_eq("rr_order", DW'(w), DW'(exp_order[t]));
      if (t > 0) check_eq("grant_gap", DW'(gap), DW'(3));
    end
    for (int i = 0; i < N; i++) p_valid[i] = 1'b0;
    idle_cycle(1'b1);

    // Write from requester 1 stalled 20 cycles; others queue up meanwhile.
    apply_reset();
    set_req(1, 1'b1, 64'h40, {64{8'h55}});
    do_txn(20, 0, rand_line(), 1'b0, 1'b0, 4'b1101, w, gap);
    check_eq("write_owner", DW'(w), DW'(1));
    for (int t = 0; t < 3; t++) do_txn($urandom_range(0, 3), $urandom_range(0, 3), rand_line(), 1'b0, 1'b0, '0, w, gap);

    // Stray response in IDLE sets the sticky error.
    begin_cycle();
    bus.buffer_addr_valid = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    drive_reqs();
    sample();
    m_err_pend = 1'b1;
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    rand_req(0);
    do_txn(1, 2, rand_line(), 1'b0, 1'b0, '0, w, gap);
    idle_cycle(1'b1);

    // Reset while waiting on requester 3's response.
    set_req(3, 1'b0, 64'hBEEF, rand_line());
    do_txn(0, 3, rand_line(), 1'b0, 1'b0, '0, w, gap);
    rsp_pending = 1'b0;
    apply_reset();
    set_req(3, 1'b0, 64'h3000, rand_line());
    begin_cycle();
    bus.buffer_addr_valid = 1'b1;
    drive_reqs();
    sample();
    check_eq("abort_grant", DW'(bus.req_ready), DW'(4'b1000));
    p_valid[3] = 1'b0;
    begin_cycle();
    drive_reqs();
    bus.mem_req_ready = 1'b1;
    sample();
    check_eq("abort_issue", DW'(bus.mem_req_valid), DW'(1));
    begin_cycle();
    rst_n = 1'b0;
    drive_reqs();
    sample();
    check_eq("abort_wait_busy", DW'(bus.busy), DW'(1));
    m_ptr      = N - 1;
    m_err      = 1'b0;
    m_rsp_data = '0;
    begin_cycle();
    rst_n = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    drive_reqs();
    sample();
    check_eq("abort_idle_busy", DW'(bus.busy), DW'(0));
    m_err_pend = 1'b1;
    for (int i = 0; i < N; i++) rand_req(i);
    do_txn(0, 0, rand_line(), 1'b0, 1'b0, '0, w, gap);
    check_eq("post_reset_owner", DW'(w), DW'(0));

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      int wi;
      for (int i = 0; i < N; i++) if (!p_valid[i] && ($urandom_range(0, 1) == 1)) rand_req(i);
      if (n_pending() == 0) rand_req($urandom_range(0, N - 1));
      if ($urandom_range(0, 3) == 0) begin
        wi = $urandom_range(0, N - 1);
        if (n_pending() > 1) p_valid[wi] = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) idle_cycle(1'b0);
      do_txn($urandom_range(0, 3), $urandom_range(0, 3), rand_line(), 1'b0, 1'b1, '0, w, gap);
    end
    idle_cycle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
